sc_stream_gen: RTL and testbench

Upstream stochastic number generator for the SC neuron datapath. Accepts one frame of N_CH unsigned binary values (inputs, weights, bias), then spends STREAM_LEN cycles converting each to a unipolar stochastic bitstream by LFSR comparison. Presents all streams in parallel as STREAM_LEN-bit words, ready for the neuron's AND-multiply / scaled-add stage. Valid/ready handshake on both sides.

---
 rtl/sc_pkg.sv | 27 ++
 rtl/sc_lfsr8.sv | 32 +++
 rtl/sc_stream_gen.sv | 98 +++++++++
 tb/tb_sc_stream_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared constants, seeds, LFSR step and FSM state for the SC stream generator
package sc_pkg;

  localparam int SC_N_CH       = 7;
  localparam int SC_VALUE_W    = 8;
  localparam int SC_STREAM_LEN = 64;
  localparam int SC_LFSR_W     = 8;

  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [SC_LFSR_W-1:0] SC_TAP_MASK = 8'hB8;

  // Channel c seed is SC_SEED[c]; all distinct and nonzero so no channel can lock up.
  localparam logic [SC_N_CH-1:0][SC_LFSR_W-1:0] SC_SEED = {
    8'hE8, 8'h71, 8'h96, 8'h2F, 8'hC3, 8'h5A, 8'h01
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [SC_LFSR_W-1:0] lfsr_next(input logic [SC_LFSR_W-1:0] q);
    return {q[SC_LFSR_W-2:0], ^(q & SC_TAP_MASK)};
  endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// rtl/sc_lfsr8.sv - 8-bit Fibonacci LFSR, reseeded on rst, advances only while en
module sc_lfsr8
  import sc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SC_LFSR_W-1:0] seed,
  output logic [SC_LFSR_W-1:0] q
);

  logic [SC_LFSR_W-1:0] q_q;
  logic [SC_LFSR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sc_stream_gen.sv
// rtl/sc_stream_gen.sv - converts a frame of binary values into parallel unipolar stochastic streams
module sc_stream_gen
  import sc_pkg::*;
#(
  parameter int N_CH       = SC_N_CH,
  parameter int VALUE_W    = SC_VALUE_W,
  parameter int STREAM_LEN = SC_STREAM_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_CH*VALUE_W-1:0]      in_values,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_CH*STREAM_LEN-1:0]   out_streams,
  output logic                         busy
);

  localparam int CNT_W = $clog2(STREAM_LEN);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [N_CH*VALUE_W-1:0]      value_q, value_d;
  logic [N_CH*STREAM_LEN-1:0]   stream_q, stream_d;
  logic [N_CH*SC_LFSR_W-1:0]    lfsr_q;
  logic                         lfsr_en;

  // LFSRs run only during GEN so the sequence carries on from frame to frame.
  assign lfsr_en = (state_q == ST_GEN);

  for (genvar g = 0; g < N_CH; g++) begin : g_lfsr
    sc_lfsr8 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .en   (lfsr_en),
      .seed (SC_SEED[g]),
      .q    (lfsr_q[g*SC_LFSR_W +: SC_LFSR_W])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    stream_d = stream_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          value_d  = in_values;
          stream_d = '0;
          cnt_d    = '0;
          state_d  = ST_GEN;
        end
      end
      ST_GEN: begin
        // Bit index equals GEN cycle index; compare uses the LFSR value before this cycle's step.
        for (int c = 0; c < N_CH; c++) begin
          stream_d[c*STREAM_LEN + int'(cnt_q)] =
            (value_q[c*VALUE_W +: VALUE_W] > lfsr_q[c*SC_LFSR_W +: SC_LFSR_W]);
        end
        if (cnt_q == CNT_W'(STREAM_LEN-1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      value_q  <= '0;
      stream_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      stream_q <= stream_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q == ST_GEN);
  assign out_streams = stream_q;

endmodule

// File: tb/tb_sc_stream_gen.sv
// tb/tb_sc_stream_gen.sv - directed self-checking bench for sc_stream_gen
module tb_sc_stream_gen;

  localparam int NC = 7;
  localparam int VW = 8;
  localparam int SL = 64;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NC*VW-1:0]  in_values;
  logic              out_valid;
  logic              out_ready;
  logic [NC*SL-1:0]  out_streams;
  logic              busy;

  int tests_run;
  int tests_failed;

  logic [7:0] seeds  [NC] = '{8'h01, 8'h5A, 8'hC3, 8'h2F, 8'h96, 8'h71, 8'hE8};
  logic [7:0] m_lfsr [NC];

  sc_stream_gen dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_values   (in_values),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_streams (out_streams),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) m_lfsr[c] = seeds[c];
  endtask

  task automatic model_frame(input logic [NC*VW-1:0] v, output logic [NC*SL-1:0] s);
    s = '0;
    for (int k = 0; k < SL; k++) begin
      for (int c = 0; c < NC; c++) begin
        s[c*SL + k] = (v[c*VW +: VW] > m_lfsr[c]);
        m_lfsr[c]   = m_step(m_lfsr[c]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input logic [NC*VW-1:0] v, output logic [NC*SL-1:0] exp);
    int lat;
    model_frame(v, exp);
    in_values = v;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_values = ~v;
    chk("gen_busy", 512'(busy), 512'(1));
    chk("gen_in_ready", 512'(in_ready), 512'(0));
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("latency", 512'(lat), 512'(64));
    chk("out_valid", 512'(out_valid), 512'(1));
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [NC*VW-1:0] pat(input int i);
    logic [NC*VW-1:0] p;
    for (int c = 0; c < NC; c++) p[c*VW +: VW] = 8'(i*29 + c*53 + 7);
    return p;
  endfunction

  initial begin
    logic [NC*SL-1:0] exp_a, exp_b, got_a, snap, e0, e1;
    logic [NC*VW-1:0] v5;
    logic             hold_valid, hold_stream, hold_ready;
    int               pc;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    in_values    = '0;

    // reset state
    do_reset();
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_streams", 512'(out_streams), 512'(0));

    // all-zero values
    run_frame('0, exp_a);
    chk("zero_streams", 512'(out_streams), 512'(0));
    release_done();

    // ch0 full scale, others half
    do_reset();
    run_frame({{6{8'h80}}, 8'hFF}, exp_a);
    chk("ff_streams", 512'(out_streams), 512'(exp_a));
    pc = $countones(out_streams[SL-1:0]);
    chk("ff_popcount_ge63", 512'(pc >= 63), 512'(1));
    release_done();

    // back-to-back frames continue the LFSR sequence
    do_reset();
    run_frame({NC{8'h80}}, exp_a);
    chk("b2b_a_streams", 512'(out_streams), 512'(exp_a));
    chk("hand_ch0_low8", 512'(out_streams[7:0]), 512'(8'h7F));
    got_a = out_streams;
    release_done();
    chk("idle_after_release", 512'(in_ready), 512'(1));
    run_frame({NC{8'h80}}, exp_b);
    chk("b2b_b_streams", 512'(out_streams), 512'(exp_b));
    chk("b2b_differs", 512'(out_streams != got_a), 512'(1));

    // DONE held with out_ready low while in_valid pokes at it
    snap        = out_streams;
    hold_valid  = 1'b1;
    hold_stream = 1'b1;
    hold_ready  = 1'b1;
    in_valid    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_values = pat(i);
      tick();
      if (out_valid !== 1'b1) hold_valid = 1'b0;
      if (out_streams !== snap) hold_stream = 1'b0;
      if (in_ready !== 1'b0 || busy !== 1'b0) hold_ready = 1'b0;
    end
    in_valid = 1'b0;
    chk("hold_out_valid", 512'(hold_valid), 512'(1));
    chk("hold_streams", 512'(hold_stream), 512'(1));
    chk("hold_in_ready", 512'(hold_ready), 512'(1));
    release_done();
    chk("hold_rel_in_ready", 512'(in_ready), 512'(1));
    chk("hold_rel_out_valid", 512'(out_valid), 512'(0));
    run_frame(56'h00_FF_40_C0_10_E0_33, exp_a);
    chk("after_hold_streams", 512'(out_streams), 512'(exp_a));
    release_done();

    // rst mid-GEN, together with in_valid
    do_reset();
    v5        = 56'h12_34_56_78_9A_BC_DE;
    in_values = v5;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    rst       = 1'b1;
    in_valid  = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    model_reset();
    chk("midrst_in_ready", 512'(in_ready), 512'(1));
    chk("midrst_busy", 512'(busy), 512'(0));
    chk("midrst_out_valid", 512'(out_valid), 512'(0));
    chk("midrst_streams", 512'(out_streams), 512'(0));
    run_frame(v5, exp_a);
    chk("midrst_replay", 512'(out_streams), 512'(exp_a));
    release_done();

    // in_valid held high with changing values; frames every 66 cycles
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 132; i++) begin
      in_values = pat(i);
      if (i == 0) begin
        chk("stream_acc0_ready", 512'(in_ready), 512'(1));
        model_frame(pat(i), e0);
      end
      if (i == 66) begin
        chk("stream_acc1_ready", 512'(in_ready), 512'(1));
        model_frame(pat(i), e1);
      end
      if (i == 65) chk("stream_done_ready", 512'(in_ready), 512'(0));
      tick();
      if (i == 63)  chk("stream_f0_early", 512'(out_valid), 512'(0));
      if (i == 64)  chk("stream_f0_valid", 512'(out_valid), 512'(1));
      if (i == 64)  chk("stream_f0_data", 512'(out_streams), 512'(e0));
      if (i == 129) chk("stream_f1_early", 512'(out_valid), 512'(0));
      if (i == 130) chk("stream_f1_valid", 512'(out_valid), 512'(1));
      if (i == 130) chk("stream_f1_data", 512'(out_streams), 512'(e1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
